// File: rtl/fetch_if.sv
// Fetch stage bundle: decode/execute control inputs, BRAM port and fetched-instruction outputs.
// The fetch unit takes the master modport; its environment takes the slave modport.
interface fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        wait_load;
  logic [4:0]  wait_time;
  logic        stop;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;
  logic        halted;
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  modport master (
    input  stall, redirect, redirect_pc, wait_load, wait_time, stop, imem_rdata,
    output imem_addr, imem_en, pc, inst, valid, halted, perf_fetched, perf_bubbles
  );

  modport slave (
    output stall, redirect, redirect_pc, wait_load, wait_time, stop, imem_rdata,
    input  imem_addr, imem_en, pc, inst, valid, halted, perf_fetched, perf_bubbles
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: RUN/WAIT/HALT sequencer feeding a 1-cycle-latency instruction BRAM.
// Defining FETCH_PERF_EN adds the fetched/bubble performance counters; otherwise they read 0.
module fetch (
  input  logic     clk,
  input  logic     rstn,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

  state_t      r_state, w_stateNext;
  logic [31:0] r_fpc, w_fpcNext;
  logic [31:0] r_pc, w_pcNext;
  logic        r_valid, w_validNext;
  logic [4:0]  r_cnt, w_cntNext;
  logic        w_update;

  assign bus.imem_addr = r_fpc[15:2];
  assign bus.imem_en   = (r_state == ST_RUN) && !bus.stall;
  assign bus.inst      = bus.imem_rdata;
  assign bus.pc        = r_pc;
  assign bus.valid     = r_valid;
  assign bus.halted    = (r_state == ST_HALT);

  // w_update marks every edge that is not a hold; stall and HALT leave all state untouched.
  always_comb begin
    w_stateNext = r_state;
    w_fpcNext   = r_fpc;
    w_pcNext    = r_pc;
    w_validNext = r_valid;
    w_cntNext   = r_cnt;
    w_update    = 1'b0;
    if (r_state != ST_HALT) begin
      if (bus.stop) begin
        w_update    = 1'b1;
        w_stateNext = ST_HALT;
        w_validNext = 1'b0;
      end else if (bus.redirect) begin
        w_update    = 1'b1;
        w_fpcNext   = {bus.redirect_pc[31:2], 2'b00};
        w_validNext = 1'b0;
      end else if (bus.wait_load && (bus.wait_time != 5'd0) && (r_state == ST_RUN)) begin
        w_update    = 1'b1;
        w_cntNext   = bus.wait_time;
        w_stateNext = ST_WAIT;
        w_validNext = 1'b0;
      end else if (!bus.stall) begin
        w_update = 1'b1;
        // The load edge already counted as one bubble, so the counter=1 edge fetches again;
        // the BRAM still holds the word read at fpc on that load edge.
        if ((r_state == ST_WAIT) && (r_cnt > 5'd1)) begin
          w_cntNext   = r_cnt - 5'd1;
          w_validNext = 1'b0;
        end else begin
          w_stateNext = ST_RUN;
          w_cntNext   = 5'd0;
          w_pcNext    = r_fpc;
          w_fpcNext   = r_fpc + 32'd4;
          w_validNext = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state <= ST_RUN;
      r_fpc   <= 32'd0;
      r_pc    <= 32'd0;
      r_valid <= 1'b0;
      r_cnt   <= 5'd0;
    end else if (w_update) begin
      r_state <= w_stateNext;
      r_fpc   <= w_fpcNext;
      r_pc    <= w_pcNext;
      r_valid <= w_validNext;
      r_cnt   <= w_cntNext;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perfFetched;
  logic [31:0] r_perfBubbles;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_perfFetched <= 32'd0;
      r_perfBubbles <= 32'd0;
    end else if (w_update) begin
      if (w_validNext) begin
        r_perfFetched <= r_perfFetched + 32'd1;
      end else begin
        r_perfBubbles <= r_perfBubbles + 32'd1;
      end
    end
  end

  assign bus.perf_fetched = r_perfFetched;
  assign bus.perf_bubbles = r_perfBubbles;
`else
  assign bus.perf_fetched = 32'd0;
  assign bus.perf_bubbles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage with a behavioural 1-cycle-latency BRAM.
// Perf expectations follow FETCH_PERF_EN so both builds are covered.
module tb_fetch;

`ifdef FETCH_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  int   nTests = 0;
  int   nFail  = 0;

  fetch_if bus ();

  fetch dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [13:0] a);
    return 32'hDEAD0000 ^ {18'd0, a};
  endfunction

  function automatic logic [31:0] instAt(input logic [31:0] bytePc);
    return memWord(bytePc[15:2]);
  endfunction

  // Behavioural BRAM: registered read, output holds while imem_en is low.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= memWord(bus.imem_addr);
  end

  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic wl, input logic [4:0] wt, input logic sp);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.wait_load   = wl;
    bus.wait_time   = wt;
    bus.stop        = sp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] pcExp, input logic validExp,
                            input logic [13:0] addrExp);
    checkOutput({tag, ".pc"}, bus.pc, pcExp);
    checkOutput({tag, ".valid"}, 32'(bus.valid), 32'(validExp));
    checkOutput({tag, ".addr"}, 32'(bus.imem_addr), 32'(addrExp));
    if (validExp) checkOutput({tag, ".inst"}, bus.inst, instAt(pcExp));
  endtask

  initial begin
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    #12;
    checkFetch("reset", 32'd0, 1'b0, 14'd0);
    checkOutput("reset.halted", 32'(bus.halted), 32'd0);
    checkOutput("reset.perfF", bus.perf_fetched, 32'd0);
    checkOutput("reset.perfB", bus.perf_bubbles, 32'd0);
    rstn = 1'b0;

    // Sequential fetch from address 0
    tick(); checkFetch("seq0", 32'h0, 1'b1, 14'd1);
    tick(); checkFetch("seq1", 32'h4, 1'b1, 14'd2);
    tick(); checkFetch("seq2", 32'h8, 1'b1, 14'd3);
    tick(); checkFetch("seq3", 32'hC, 1'b1, 14'd4);

    // Stall at fpc=0x10
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("stall.en", 32'(bus.imem_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); checkFetch("stall", 32'hC, 1'b1, 14'd4);
      checkOutput("stall.en", 32'(bus.imem_en), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick(); checkFetch("unstall", 32'h10, 1'b1, 14'd5);
    tick(); checkFetch("seq5", 32'h14, 1'b1, 14'd6);
    tick(); checkFetch("seq6", 32'h18, 1'b1, 14'd7);
    tick(); checkFetch("seq7", 32'h1C, 1'b1, 14'd8);

    // Redirect at fpc=0x20 to misaligned 0x103
    applyStimulus(1'b0, 1'b1, 32'h103, 1'b0, 5'd0, 1'b0);
    tick(); checkFetch("redir", 32'h1C, 1'b0, 14'h40);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick(); checkFetch("redir1", 32'h100, 1'b1, 14'h41);
    tick(); checkFetch("redir2", 32'h104, 1'b1, 14'h42);

    // Three-cycle load wait, then a zero wait_time that must be ignored
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 5'd3, 1'b0);
    tick(); checkFetch("wait0", 32'h104, 1'b0, 14'h42);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("wait.en", 32'(bus.imem_en), 32'd0);
    tick(); checkFetch("wait1", 32'h104, 1'b0, 14'h42);
    tick(); checkFetch("wait2", 32'h104, 1'b0, 14'h42);
    tick(); checkFetch("waitEnd", 32'h108, 1'b1, 14'h43);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 5'd0, 1'b0);
    tick(); checkFetch("wait0ign", 32'h10C, 1'b1, 14'h44);

    // stop beats redirect; HALT ignores everything afterwards
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 5'd0, 1'b1);
    tick(); checkFetch("halt", 32'h10C, 1'b0, 14'h44);
    checkOutput("halt.halted", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 5'($urandom), 1'($urandom));
      tick();
      checkOutput("halt.valid", 32'(bus.valid), 32'd0);
      checkOutput("halt.halted", 32'(bus.halted), 32'd1);
      checkOutput("halt.pc", bus.pc, 32'h10C);
      checkOutput("halt.en", 32'(bus.imem_en), 32'd0);
    end

    // Asynchronous reset out of HALT
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    rstn = 1'b1;
    #1;
    checkFetch("rst2", 32'd0, 1'b0, 14'd0);
    checkOutput("rst2.halted", 32'(bus.halted), 32'd0);
    checkOutput("rst2.perfF", bus.perf_fetched, 32'd0);
    checkOutput("rst2.perfB", bus.perf_bubbles, 32'd0);
    rstn = 1'b0;
    tick(); checkFetch("rst2.f0", 32'h0, 1'b1, 14'd1);

    // Perf: 5 fetches, 1 redirect, 2-cycle wait
    tick(); tick(); tick();
    tick(); checkFetch("perf.f4", 32'h10, 1'b1, 14'd5);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 5'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick(); checkFetch("perf.bub", 32'h10, 1'b0, 14'h10);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("perf.fetched", bus.perf_fetched, PerfOn ? 32'd5 : 32'd0);
    checkOutput("perf.bubbles", bus.perf_bubbles, PerfOn ? 32'd3 : 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick(); checkFetch("perf.resume", 32'h40, 1'b1, 14'h11);
    checkOutput("perf.fetched6", bus.perf_fetched, PerfOn ? 32'd6 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1, reset: asynchronous, active-high (1 = in reset).
REQ-003 SHALL have port stall, input, 1, downstream hazard hold; freezes outputs and state.
REQ-004 SHALL have port redirect, input, 1, taken jump/branch/jr from decode/execute.
REQ-005 SHALL have port redirect_pc, input, 32, byte target of redirect.
REQ-006 SHALL have port wait_load, input, 1, load bubble count from decode wait_time.
REQ-007 SHALL have port wait_time, input, 5, bubble count, 0..31.
REQ-008 SHALL have port stop, input, 1, halt request from decode stop.
REQ-009 SHALL have port imem_addr, output, 14, word address = fpc[15:2].
REQ-010 SHALL have port imem_en, output, 1, BRAM read enable; BRAM output holds when low.
REQ-011 SHALL have port imem_rdata, input, 32, BRAM data, 1-cycle read latency.
REQ-012 SHALL have ports pc (output, 32, byte PC of inst) and inst (output, 32, driven combinationally from imem_rdata).
REQ-013 SHALL have port valid, output, 1, pc/inst pair is a live instruction.
REQ-014 SHALL have port halted, output, 1, high in HALT state.
REQ-015 SHALL have ports perf_fetched and perf_bubbles, output, 32 each, performance counters.

Function
REQ-016 SHALL hold fetch address register fpc; imem_addr SHALL be fpc[15:2] every cycle.
REQ-017 SHALL implement states RUN, WAIT, HALT; imem_en SHALL be 1 only in RUN with stall=0.
REQ-018 In RUN with stall=0 and no other event, an edge SHALL do: pc<=fpc, fpc<=fpc+4 (mod 2^32), valid<=1.
REQ-019 stall=1 with no redirect/stop SHALL hold pc, valid, fpc, state and wait counter unchanged.
REQ-020 redirect=1 SHALL override stall: fpc<=redirect_pc with bits[1:0] forced 0, valid<=0 (squash), state unchanged.
REQ-021 wait_load=1 with wait_time=N>0 in RUN (no redirect) SHALL load counter N, enter WAIT, valid<=0, fpc unchanged.
REQ-022 wait_load=1 with wait_time=0 SHALL be ignored.
REQ-023 In WAIT with stall=0, each edge SHALL decrement counter with valid<=0; at counter=1 the edge SHALL return to RUN, giving exactly N bubble cycles.
REQ-024 redirect during WAIT SHALL update fpc and SHALL NOT change counter.
REQ-025 stop=1 SHALL enter HALT from any state next edge, valid<=0; HALT SHALL persist until reset, ignoring all inputs.
REQ-026 Same-cycle priority SHALL be stop > redirect > wait_load > stall.
REQ-027 wait_load while already in WAIT SHALL be ignored.

Reset
REQ-028 rstn=1 SHALL asynchronously set fpc=0, pc=0, valid=0, state=RUN, counter=0, halted=0, perf counters=0.
REQ-029 Reset asserted mid-WAIT or in HALT SHALL abandon it; first edge after release SHALL fetch address 0.

Configuration
REQ-030 With FETCH_PERF_EN defined: perf_fetched SHALL increment on each edge setting valid<=1; perf_bubbles on each edge setting valid<=0 outside HALT; both wrap at 2^32 and hold during stall.
REQ-031 Without FETCH_PERF_EN: perf_fetched and perf_bubbles SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-032 Reset release, no events, 4 cycles -> pc 0,4,8,12 with valid=1; imem_addr 1,2,3,4 in matching cycles.
REQ-033 At fpc=0x10 assert stall 3 cycles -> pc/valid/imem_addr frozen, imem_en=0; then pc=0x10 next.
REQ-034 At fpc=0x20 pulse redirect with redirect_pc=0x103 -> one valid=0 cycle, then pc=0x100, 0x104.
REQ-035 wait_load with wait_time=3 -> exactly 3 valid=0 cycles, then fetch resumes at held fpc; wait_time=0 -> no bubble.
REQ-036 stop together with redirect -> HALT, halted=1, valid=0 for 50 cycles; rstn pulse -> pc=0 fetched again.
REQ-037 FETCH_PERF_EN build: 5 fetches, 1 redirect, wait 2 -> perf_fetched=5, perf_bubbles=3; build without macro -> both 0.
